resp_misr_checker: RTL

RESP_MISR_CHECKER -- requirements
Module: resp_misr_checker

---
 rtl/resp_chk_pkg.sv | 19 +
 rtl/resp_fold.sv | 26 ++
 rtl/resp_misr_checker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/resp_chk_pkg.sv
// Shared types and constants for the response MISR checker.
// Optional serial readout is enabled by RESP_CHK_SERIAL_OUT_EN.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  function automatic int chunk_count(input int yw, input int sw);
    return (yw + sw - 1) / sw;
  endfunction

endpackage

// File: rtl/resp_fold.sv
// XOR fold of a wide response word into one signature-width chunk.
// The top chunk is zero-padded when Y_W is not a multiple of SIG_W.
module resp_fold
  import resp_chk_pkg::*;
#(
  parameter int Y_W   = 242,
  parameter int SIG_W = 32
) (
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] fold
);

  localparam int NCH = chunk_count(Y_W, SIG_W);

  logic [NCH*SIG_W-1:0] pad;

  always_comb begin
    pad = '0;
    pad[Y_W-1:0] = y;
    fold = '0;
    for (int i = 0; i < NCH; i++) begin
      fold = fold ^ pad[i*SIG_W +: SIG_W];
    end
  end

endmodule

// File: rtl/resp_misr_checker.sv
// Captures DUT responses into a MISR signature and compares to golden.
// RESP_CHK_SERIAL_OUT_EN adds an MSB-first serial dump of the result.
module resp_misr_checker
  import resp_chk_pkg::*;
#(
  parameter int               Y_W   = 242,
  parameter int               SIG_W = 32,
  parameter int               CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] skip,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sample_en,
  input  logic [Y_W-1:0]   y,
  input  logic [SIG_W-1:0] expect_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             match
`ifdef RESP_CHK_SERIAL_OUT_EN
  ,
  output logic             sdo,
  output logic             sdo_valid
`endif
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] skip_cnt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] skip_d;
  logic [CNT_W-1:0] rem_d;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fold;

  resp_fold #(
    .Y_W  (Y_W),
    .SIG_W(SIG_W)
  ) u_fold (
    .y   (y),
    .fold(fold)
  );

  always_comb begin
    nxt    = state;
    sig_d  = sig;
    skip_d = skip_cnt;
    rem_d  = rem;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d  = SEED;
          skip_d = skip;
          rem_d  = num_samples;
          if (skip != '0)             nxt = S_WARMUP;
          else if (num_samples != '0) nxt = S_CAPTURE;
          else                        nxt = S_DONE;
        end
      end
      S_WARMUP: begin
        skip_d = skip_cnt - 1'b1;
        if (skip_cnt == CNT_W'(1))
          nxt = (rem == '0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (sample_en) begin
          sig_d = {sig[SIG_W-2:0], 1'b0}
                ^ (sig[SIG_W-1] ? POLY : '0)
                ^ fold;
          rem_d = rem - 1'b1;
          if (rem == CNT_W'(1)) nxt = S_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sig      <= SEED;
      skip_cnt <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      sig      <= sig_d;
      skip_cnt <= skip_d;
      rem      <= rem_d;
      busy     <= (nxt == S_WARMUP) || (nxt == S_CAPTURE);
      done     <= (nxt == S_DONE);
    end
  end

  assign match = done && (sig == expect_sig);

`ifdef RESP_CHK_SERIAL_OUT_EN
  localparam int SC_W = $clog2(SIG_W + 1);

  logic [SIG_W-1:0] sh;
  logic [SC_W-1:0]  sh_cnt;
  logic             enter;

  // A start that lands straight back in DONE is a fresh entry too.
  assign enter = (nxt == S_DONE) && ((state != S_DONE) || start);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      sh_cnt <= '0;
    end else if (enter) begin
      sh     <= sig_d;
      sh_cnt <= SC_W'(SIG_W);
    end else if (start) begin
      sh     <= '0;
      sh_cnt <= '0;
    end else if (sh_cnt != '0) begin
      sh     <= {sh[SIG_W-2:0], 1'b0};
      sh_cnt <= sh_cnt - 1'b1;
    end
  end

  assign sdo       = sh[SIG_W-1];
  assign sdo_valid = (sh_cnt != '0);
`endif

endmodule
